// File: rtl/hpdmc_mgmt_seq.sv
// SDRAM command sequencer: turns FML management requests into ACT/RD/WR/PRE/REF
// commands, tracks one open row per bank and schedules periodic auto refresh.
module hpdmc_mgmt_seq #(
  parameter int sdram_depth       = 26,
  parameter int sdram_columndepth = 9,
  parameter int sdram_rowdepth    = 13,
  parameter int tim_rp            = 2,
  parameter int tim_rcd           = 2,
  parameter int tim_rfc           = 8,
  parameter int tim_refi          = 740
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      mgmt_stb,
  input  logic                      mgmt_we,
  input  logic [sdram_depth-3:0]    mgmt_address,
  output logic                      mgmt_ack,
  input  logic                      read_safe,
  input  logic                      write_safe,
  output logic                      read,
  output logic                      write,
  output logic                      sdram_cs_n,
  output logic                      sdram_ras_n,
  output logic                      sdram_cas_n,
  output logic                      sdram_we_n,
  output logic [1:0]                sdram_ba,
  output logic [sdram_rowdepth-1:0] sdram_adr
);

  localparam int TW = $clog2(tim_rp + tim_rcd + tim_rfc + 1);
  localparam int RW = $clog2(tim_refi + 1);
  localparam logic [sdram_rowdepth-1:0] ADR_A10 = sdram_rowdepth'(1024);

  typedef enum logic [3:0] {
    IDLE, PRECHARGE, WAIT_RP, ACTIVATE, WAIT_RCD, ISSUE,
    PRECHARGE_ALL, WAIT_RP_ALL, REFRESH, WAIT_RFC
  } state_t;

  state_t                       state;
  logic [sdram_columndepth-1:0] in_col, req_col;
  logic [1:0]                   in_bank, req_bank;
  logic [sdram_rowdepth-1:0]    in_row, req_row;
  logic                         req_we;
  logic [3:0]                   bank_open;
  logic [sdram_rowdepth-1:0]    bank_row [4];
  logic [TW-1:0]                wait_cnt;
  logic [RW-1:0]                refi_cnt;
  logic                         refresh_pending;
  logic                         issue_safe;

  assign in_col     = mgmt_address[sdram_columndepth-1:0];
  assign in_bank    = mgmt_address[sdram_columndepth+1 -: 2];
  assign in_row     = mgmt_address[sdram_columndepth+2 +: sdram_rowdepth];
  assign issue_safe = req_we ? write_safe : read_safe;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      sdram_cs_n      <= 1'b1;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b111;
      sdram_ba        <= '0;
      sdram_adr       <= '0;
      mgmt_ack        <= 1'b0;
      read            <= 1'b0;
      write           <= 1'b0;
      bank_open       <= '0;
      for (int i = 0; i < 4; i++) bank_row[i] <= '0;
      req_col         <= '0;
      req_bank        <= '0;
      req_row         <= '0;
      req_we          <= 1'b0;
      wait_cnt        <= '0;
      refi_cnt        <= RW'(tim_refi);
      refresh_pending <= 1'b0;
    end else begin
      // Every cycle defaults to NOP with strobes low; states override below.
      sdram_cs_n <= 1'b0;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b111;
      mgmt_ack   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;

      case (state)
        IDLE: begin
          if (refresh_pending) begin
            state <= PRECHARGE_ALL;
          end else if (mgmt_stb) begin
            req_col  <= in_col;
            req_bank <= in_bank;
            req_row  <= in_row;
            req_we   <= mgmt_we;
            if (!bank_open[in_bank])              state <= ACTIVATE;
            else if (bank_row[in_bank] == in_row) state <= ISSUE;
            else                                  state <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b010;
          sdram_ba            <= req_bank;
          sdram_adr           <= '0;
          bank_open[req_bank] <= 1'b0;
          if (tim_rp > 1) begin
            wait_cnt <= TW'(tim_rp - 2);
            state    <= WAIT_RP;
          end else begin
            state <= ACTIVATE;
          end
        end
        WAIT_RP: begin
          if (wait_cnt == '0) state <= ACTIVATE;
          else                wait_cnt <= wait_cnt - TW'(1);
        end
        ACTIVATE: begin
          {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b011;
          sdram_ba            <= req_bank;
          sdram_adr           <= req_row;
          bank_open[req_bank] <= 1'b1;
          bank_row[req_bank]  <= req_row;
          if (tim_rcd > 1) begin
            wait_cnt <= TW'(tim_rcd - 2);
            state    <= WAIT_RCD;
          end else begin
            state <= ISSUE;
          end
        end
        WAIT_RCD: begin
          if (wait_cnt == '0) state <= ISSUE;
          else                wait_cnt <= wait_cnt - TW'(1);
        end
        ISSUE: begin
          if (issue_safe) begin
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= req_we ? 3'b100 : 3'b101;
            sdram_ba  <= req_bank;
            sdram_adr <= sdram_rowdepth'(req_col);
            mgmt_ack  <= 1'b1;
            read      <= ~req_we;
            write     <= req_we;
            state     <= IDLE;
          end
        end
        PRECHARGE_ALL: begin
          {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b010;
          sdram_adr <= ADR_A10;
          bank_open <= '0;
          if (tim_rp > 1) begin
            wait_cnt <= TW'(tim_rp - 2);
            state    <= WAIT_RP_ALL;
          end else begin
            state <= REFRESH;
          end
        end
        WAIT_RP_ALL: begin
          if (wait_cnt == '0) state <= REFRESH;
          else                wait_cnt <= wait_cnt - TW'(1);
        end
        REFRESH: begin
          {sdram_ras_n, sdram_cas_n, sdram_we_n} <= 3'b001;
          refresh_pending <= 1'b0;
          if (tim_rfc > 1) begin
            wait_cnt <= TW'(tim_rfc - 2);
            state    <= WAIT_RFC;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RFC: begin
          if (wait_cnt == '0) state <= IDLE;
          else                wait_cnt <= wait_cnt - TW'(1);
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a new refresh falling due wins over the clear in REFRESH.
      if (refi_cnt == RW'(1)) begin
        refi_cnt        <= RW'(tim_refi);
        refresh_pending <= 1'b1;
      end else begin
        refi_cnt <= refi_cnt - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hpdmc_mgmt_seq.sv
// Directed bench for hpdmc_mgmt_seq: a request table on one instance, plus reset
// and refresh sequences (the refresh one on a second instance with a short interval).
module tb_hpdmc_mgmt_seq;

  localparam int TIM_RP  = 2;
  localparam int TIM_RCD = 2;
  localparam int TIM_RFC = 8;
  localparam int REFI_R  = 20;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101,
                         C_WR  = 3'b100, C_PRE = 3'b010, C_REF = 3'b001;

  typedef struct {
    logic        we;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    int          dly;      // safe input for the direction held low while n <= dly
    logic        exp_pre;
    logic        exp_act;
    int          exp_lat;  // cycles from stb to ack
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1, stb = 1'b0, we = 1'b0, read_safe = 1'b1, write_safe = 1'b1;
  logic [23:0] addr = '0;
  logic        ack, rd, wr, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] adr;
  logic [2:0]  cmd;
  assign cmd = {ras_n, cas_n, we_n};

  logic        rst_r_n = 1'b1, stb_r = 1'b0;
  logic [23:0] addr_r = '0;
  logic        ack_r, rd_r, wr_r, cs_n_r, ras_n_r, cas_n_r, we_n_r;
  logic [1:0]  ba_r;
  logic [12:0] adr_r;
  logic [2:0]  cmd_r;
  assign cmd_r = {ras_n_r, cas_n_r, we_n_r};

  hpdmc_mgmt_seq dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .mgmt_stb(stb), .mgmt_we(we), .mgmt_address(addr),
    .mgmt_ack(ack), .read_safe(read_safe), .write_safe(write_safe), .read(rd), .write(wr),
    .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
    .sdram_ba(ba), .sdram_adr(adr)
  );

  hpdmc_mgmt_seq #(.tim_refi(REFI_R)) dut_r (
    .sys_clk(clk), .sys_rst_n(rst_r_n), .mgmt_stb(stb_r), .mgmt_we(1'b0), .mgmt_address(addr_r),
    .mgmt_ack(ack_r), .read_safe(1'b1), .write_safe(1'b1), .read(rd_r), .write(wr_r),
    .sdram_cs_n(cs_n_r), .sdram_ras_n(ras_n_r), .sdram_cas_n(cas_n_r), .sdram_we_n(we_n_r),
    .sdram_ba(ba_r), .sdram_adr(adr_r)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input int b, input int r, input int c, input int d,
                              input logic p, input logic a, input int lat);
    vec_t v;
    v.we = w; v.bank = 2'(b); v.row = 13'(r); v.col = 9'(c); v.dly = d;
    v.exp_pre = p; v.exp_act = a; v.exp_lat = lat;
    return v;
  endfunction

  // n counts negedges after stb rises; a command registered at the k-th posedge shows at n=k.
  task automatic run_req(input int idx, input vec_t v);
    int n = 0, pre_n = -1, act_n = -1, rw_n = -1, extra = 0;
    logic [1:0]  pre_ba = '0, act_ba = '0, rw_ba = '0;
    logic [12:0] pre_adr = '0, act_adr = '0, rw_adr = '0;
    logic [2:0]  rw_cmd = C_NOP;
    logic        rd_at = 1'b0, wr_at = 1'b0, ack_at = 1'b0;
    string       tag = $sformatf("v%0d", idx);
    addr       = {v.row, v.bank, v.col};
    we         = v.we;
    read_safe  = !(v.dly > 0 && !v.we);
    write_safe = !(v.dly > 0 && v.we);
    stb        = 1'b1;
    while (rw_n < 0 && n < 30) begin
      @(posedge clk); @(negedge clk); n++;
      case (cmd)
        C_PRE: if (pre_n < 0) begin pre_n = n; pre_ba = ba; pre_adr = adr; end else extra++;
        C_ACT: if (act_n < 0) begin act_n = n; act_ba = ba; act_adr = adr; end else extra++;
        C_RD, C_WR: begin
          rw_n = n; rw_cmd = cmd; rw_ba = ba; rw_adr = adr;
          rd_at = rd; wr_at = wr; ack_at = ack;
        end
        C_NOP: begin end
        default: extra++;
      endcase
      if (ack && rw_n < 0) extra++;
      if (n > v.dly) begin read_safe = 1'b1; write_safe = 1'b1; end
    end
    stb = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_post_strobes"}, int'({ack, rd, wr}), 0);
    chk({tag, "_pre_cyc"}, pre_n, v.exp_pre ? 2 : -1);
    if (v.exp_pre) begin
      chk({tag, "_pre_ba"}, int'(pre_ba), int'(v.bank));
      chk({tag, "_pre_a10"}, int'(pre_adr[10]), 0);
    end
    chk({tag, "_act_cyc"}, act_n, v.exp_act ? (v.exp_pre ? 2 + TIM_RP : 2) : -1);
    if (v.exp_act) begin
      chk({tag, "_act_ba"}, int'(act_ba), int'(v.bank));
      chk({tag, "_act_row"}, int'(act_adr), int'(v.row));
    end
    chk({tag, "_rw_cyc"}, rw_n, v.exp_lat);
    chk({tag, "_rw_cmd"}, int'(rw_cmd), int'(v.we ? C_WR : C_RD));
    chk({tag, "_rw_ba"}, int'(rw_ba), int'(v.bank));
    chk({tag, "_rw_col"}, int'(rw_adr), int'(v.col));
    chk({tag, "_ack"}, int'(ack_at), 1);
    chk({tag, "_rdwr"}, int'({rd_at, wr_at}), int'({~v.we, v.we}));
    chk({tag, "_extra_cmds"}, extra, 0);
    $display("[TB] %s we=%0d bank=%0d row=%0d col=%0d ack after %0d cycles",
             tag, v.we, v.bank, v.row, v.col, rw_n);
  endtask

  vec_t vecs[11];

  initial begin
    int act_n;
    int pre1, pre2, ref1, act1, act2, ack1, ack2;
    logic [1:0]  act2_ba;
    logic [12:0] act2_adr;

    // Closed -> ACT + tim_rcd (lat 4); hit -> lat 2; conflict -> PRE, ACT, RW (lat 6).
    vecs[0]  = mk(1'b0, 1, 2,    4,   0, 1'b0, 1'b1, 4);  // bank 1 closed again after reset
    vecs[1]  = mk(1'b0, 0, 5,    3,   0, 1'b0, 1'b1, 4);
    vecs[2]  = mk(1'b0, 0, 5,    7,   0, 1'b0, 1'b0, 2);
    vecs[3]  = mk(1'b1, 0, 9,    1,   0, 1'b1, 1'b1, 6);
    vecs[4]  = mk(1'b1, 0, 9,    2,   4, 1'b0, 1'b0, 6);  // 4 stalled ISSUE cycles
    vecs[5]  = mk(1'b0, 1, 2,    5,   0, 1'b0, 1'b0, 2);
    vecs[6]  = mk(1'b0, 2, 2,    0,   5, 1'b0, 1'b1, 7);  // read_safe rises at 6th posedge
    vecs[7]  = mk(1'b1, 3, 8191, 511, 0, 1'b0, 1'b1, 4);
    vecs[8]  = mk(1'b0, 3, 8191, 511, 0, 1'b0, 1'b0, 2);
    vecs[9]  = mk(1'b0, 3, 0,    0,   0, 1'b1, 1'b1, 6);
    vecs[10] = mk(1'b1, 1, 3,    9,   0, 1'b1, 1'b1, 6);

    #1 rst_n = 1'b0; rst_r_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_cmd", int'(cmd), int'(C_NOP));
    chk("reset_ba_adr", int'({ba, adr}), 0);
    chk("reset_strobes", int'({ack, rd, wr}), 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("run_cs_n", int'(cs_n), 0);
    chk("run_cmd_nop", int'(cmd), int'(C_NOP));

    // Asynchronous reset right when the ACT for bank 1 is on the bus.
    addr = {13'd2, 2'd1, 9'd0}; we = 1'b0; stb = 1'b1; act_n = -1;
    for (int n = 1; n <= 10 && act_n < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (cmd == C_ACT) act_n = n;
    end
    chk("midrst_act_cyc", act_n, 2);
    rst_n = 1'b0; stb = 1'b0;
    #1;
    chk("midrst_cs_n", int'(cs_n), 1);
    chk("midrst_cmd", int'(cmd), int'(C_NOP));
    chk("midrst_ba_adr", int'({ba, adr}), 0);
    chk("midrst_strobes", int'({ack, rd, wr}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_req(i, vecs[i]);

    // Refresh on dut_r: open bank 2 row 6, then re-request it just as refresh falls due.
    pre1 = -1; pre2 = -1; ref1 = -1; act1 = -1; act2 = -1; ack1 = -1; ack2 = -1;
    act2_ba = '0; act2_adr = '0;
    addr_r = {13'd6, 2'd2, 9'd4};
    @(negedge clk);
    rst_r_n = 1'b1;
    stb_r   = 1'b1;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cmd_r == C_PRE && adr_r[10]) begin
        if (pre1 < 0) pre1 = cyc; else if (pre2 < 0) pre2 = cyc;
      end
      if (cmd_r == C_REF && ref1 < 0) ref1 = cyc;
      if (cmd_r == C_ACT) begin
        if (act1 < 0) act1 = cyc;
        else if (act2 < 0) begin act2 = cyc; act2_ba = ba_r; act2_adr = adr_r; end
      end
      if (ack_r) begin
        stb_r = 1'b0;
        if (ack1 < 0) ack1 = cyc; else if (ack2 < 0) ack2 = cyc;
      end
      if (cyc == REFI_R) stb_r = 1'b1;
    end
    chk("ref_first_ack", ack1, 2 + TIM_RCD);
    // Pending set at posedge 20, seen by IDLE at 21, PRE-all registered at 22.
    chk("ref_preall_cyc", pre1, REFI_R + 2);
    chk("ref_ref_after_pre", ref1 - pre1, TIM_RP);
    // REF cycle plus tim_rfc-1 waits, one IDLE decode cycle, then ACT (bank was closed).
    chk("ref_act_after_ref", act2 - ref1, TIM_RFC + 1);
    chk("ref_act_ba_row", int'({act2_ba, act2_adr}), int'({2'd2, 13'd6}));
    chk("ref_ack_after_act", ack2 - act2, TIM_RCD);
    chk("ref_period", pre2 - pre1, REFI_R);
    $display("[TB] refresh: pre_all@%0d ref@%0d act@%0d ack@%0d next pre_all@%0d",
             pre1, ref1, act2, ack2, pre2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
